// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage in-order core: boot hold, hazard/branch
// priority, WB trap redirects with a drain FSM that waits out outstanding dmem work.
module pipeline_ctrl #(
    parameter int BOOT_CYCLES = 2,
    parameter int DRAIN_MAX   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_stall,
    input  logic        mem_req_stall,
    input  logic        load_use_hazard,
    input  logic        ex_br_taken,
    input  logic        wb_valid,
    input  logic        wb_except,
    input  logic        wb_ret,
    output logic        PC_stall,
    output logic        IF_ID_stall,
    output logic        ID_EX_stall,
    output logic        EX_MEM_stall,
    output logic        MEM_WB_stall,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic        EX_MEM_flush,
    output logic        MEM_WB_flush,
    output logic [1:0]  pc_sel,
    output logic [31:0] stall_cycles,
    output logic [15:0] trap_count,
    output logic        drain_timeout
);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_DRAIN} state_t;

    localparam logic [1:0] PC_INC  = 2'd0;
    localparam logic [1:0] PC_BR   = 2'd1;
    localparam logic [1:0] PC_TRAP = 2'd2;
    localparam logic [1:0] PC_RET  = 2'd3;

    localparam logic [3:0] BOOT_LAST  = 4'(BOOT_CYCLES - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);

    state_t     state;
    logic [3:0] boot_cnt;
    logic [7:0] drain_cnt;
    logic       kind_ret;

    logic trap;
    logic hold_up;
    logic flush_all;
    logic trap_fire;
    logic go_drain;

    assign trap         = wb_valid & (wb_except | wb_ret);
    assign MEM_WB_stall = 1'b0;

    always_comb begin
        hold_up      = 1'b0;
        flush_all    = 1'b0;
        trap_fire    = 1'b0;
        go_drain     = 1'b0;
        PC_stall     = 1'b0;
        IF_ID_stall  = 1'b0;
        ID_EX_stall  = 1'b0;
        EX_MEM_stall = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        MEM_WB_flush = 1'b0;
        pc_sel       = PC_INC;
        case (state)
            S_RUN: begin
                if (trap && !mem_req_stall) begin
                    flush_all = 1'b1;
                    trap_fire = 1'b1;
                    pc_sel    = wb_except ? PC_TRAP : PC_RET;
                end else if (trap) begin
                    hold_up  = 1'b1;
                    go_drain = 1'b1;
                end else if (mem_req_stall) begin
                    hold_up = 1'b1;
                end else if (ex_br_taken) begin
                    // imem aborts on redirect, so if_req_stall does not hold PC here
                    IF_ID_flush = 1'b1;
                    ID_EX_flush = 1'b1;
                    pc_sel      = PC_BR;
                end else if (load_use_hazard) begin
                    PC_stall    = 1'b1;
                    IF_ID_stall = 1'b1;
                    ID_EX_flush = 1'b1;
                end else if (if_req_stall) begin
                    PC_stall    = 1'b1;
                    IF_ID_flush = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!mem_req_stall || drain_cnt == DRAIN_LAST) begin
                    flush_all = 1'b1;
                    trap_fire = 1'b1;
                    pc_sel    = kind_ret ? PC_RET : PC_TRAP;
                end else begin
                    hold_up = 1'b1;
                end
            end
            default: begin
                PC_stall  = 1'b1;
                flush_all = 1'b1;
            end
        endcase
        if (hold_up) begin
            PC_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_stall  = 1'b1;
            EX_MEM_stall = 1'b1;
            MEM_WB_flush = 1'b1;
        end
        if (flush_all) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
            MEM_WB_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_BOOT;
            boot_cnt      <= '0;
            drain_cnt     <= '0;
            kind_ret      <= 1'b0;
            stall_cycles  <= '0;
            trap_count    <= '0;
            drain_timeout <= 1'b0;
        end else begin
            if (PC_stall)  stall_cycles <= stall_cycles + 32'd1;
            if (trap_fire) trap_count   <= trap_count + 16'd1;
            case (state)
                S_BOOT: begin
                    if (boot_cnt == BOOT_LAST) begin
                        state    <= S_RUN;
                        boot_cnt <= '0;
                    end else begin
                        boot_cnt <= boot_cnt + 4'd1;
                    end
                end
                S_RUN: begin
                    if (go_drain) begin
                        state     <= S_DRAIN;
                        kind_ret  <= ~wb_except;
                        drain_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    if (trap_fire) begin
                        state     <= S_RUN;
                        drain_cnt <= '0;
                        // redirect with dmem still busy means the drain was cut short
                        if (mem_req_stall) drain_timeout <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 8'd1;
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a rule-level reference model predicts each
// cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_pipeline_ctrl;

    localparam int BOOT = 2;
    localparam int DMAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic if_req_stall = 1'b0, mem_req_stall = 1'b0, load_use_hazard = 1'b0;
    logic ex_br_taken = 1'b0, wb_valid = 1'b0, wb_except = 1'b0, wb_ret = 1'b0;
    logic PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall;
    logic IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush;
    logic [1:0]  pc_sel;
    logic [31:0] stall_cycles;
    logic [15:0] trap_count;
    logic        drain_timeout;

    pipeline_ctrl #(.BOOT_CYCLES(BOOT), .DRAIN_MAX(DMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req_stall(if_req_stall), .mem_req_stall(mem_req_stall),
        .load_use_hazard(load_use_hazard), .ex_br_taken(ex_br_taken),
        .wb_valid(wb_valid), .wb_except(wb_except), .wb_ret(wb_ret),
        .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall), .ID_EX_stall(ID_EX_stall),
        .EX_MEM_stall(EX_MEM_stall), .MEM_WB_stall(MEM_WB_stall),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
        .EX_MEM_flush(EX_MEM_flush), .MEM_WB_flush(MEM_WB_flush),
        .pc_sel(pc_sel), .stall_cycles(stall_cycles), .trap_count(trap_count),
        .drain_timeout(drain_timeout)
    );

    always #5 clk = ~clk;

    // ctl bit order: PC, IF_ID, ID_EX, EX_MEM, MEM_WB stalls, then IF_ID..MEM_WB flushes
    typedef struct {
        logic [8:0]  ctl;
        logic [1:0]  pc_sel;
        logic [31:0] stalls;
        logic [15:0] traps;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    string       m_mode;
    int          m_boot_left;
    int          m_drain_cycles;
    bit          m_ret_kind;
    logic [31:0] m_stalls;
    logic [15:0] m_traps;
    bit          m_to;

    localparam logic [8:0] HOLD  = 9'b1_1110_0001;
    localparam logic [8:0] FLALL = 9'b0_0000_1111;

    task automatic model_reset();
        m_mode = "BOOT"; m_boot_left = BOOT; m_drain_cycles = 0; m_ret_kind = 0;
        m_stalls = '0; m_traps = '0; m_to = 0;
    endtask

    task automatic step(input bit r, input bit mem, input bit ifs, input bit lu,
                        input bit br, input bit v, input bit ex, input bit ret);
        exp_t e;
        bit   trap;
        rst = r; mem_req_stall = mem; if_req_stall = ifs; load_use_hazard = lu;
        ex_br_taken = br; wb_valid = v; wb_except = ex; wb_ret = ret;
        e.ctl = '0; e.pc_sel = 2'd0;
        if (!r) begin
            model_reset();
            e.ctl = 9'b1_0000_1111; e.stalls = '0; e.traps = '0; e.to = 0;
            sb.push_back(e);
            return;
        end
        e.stalls = m_stalls; e.traps = m_traps; e.to = m_to;
        trap = v && (ex || ret);
        if (m_mode == "BOOT") begin
            e.ctl = 9'b1_0000_1111;
            m_boot_left--;
            if (m_boot_left == 0) m_mode = "RUN";
        end else if (m_mode == "RUN") begin
            if (trap && !mem) begin
                e.ctl = FLALL; e.pc_sel = ex ? 2'd2 : 2'd3; m_traps++;
            end else if (trap) begin
                e.ctl = HOLD; m_mode = "DRAIN"; m_ret_kind = !ex; m_drain_cycles = 0;
            end else if (mem)  e.ctl = HOLD;
            else if (br) begin e.ctl = 9'b0_0000_1100; e.pc_sel = 2'd1; end
            else if (lu)  e.ctl = 9'b1_1000_0100;
            else if (ifs) e.ctl = 9'b1_0000_1000;
        end else begin
            m_drain_cycles++;
            if (!mem || m_drain_cycles == DMAX) begin
                e.ctl = FLALL; e.pc_sel = m_ret_kind ? 2'd3 : 2'd2; m_traps++;
                if (mem) m_to = 1;
                m_mode = "RUN";
            end else e.ctl = HOLD;
        end
        if (e.ctl[8]) m_stalls++;
        sb.push_back(e);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp("ctl", 32'({PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall,
                            IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush}), 32'(e.ctl));
            cmp("pc_sel", 32'(pc_sel), 32'(e.pc_sel));
            cmp("stall_cycles", stall_cycles, e.stalls);
            cmp("trap_count", 32'(trap_count), 32'(e.traps));
            cmp("drain_timeout", 32'(drain_timeout), 32'(e.to));
        end
    end

    task automatic cyc(input bit mem, input bit ifs, input bit lu, input bit br,
                       input bit v, input bit ex, input bit ret);
        @(posedge clk); #1;
        step(1'b1, mem, ifs, lu, br, v, ex, ret);
    endtask

    task automatic rst_cyc();
        @(posedge clk); #1;
        step(1'b0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit mem_r;
        model_reset();
        repeat (3) rst_cyc();
        repeat (4) cyc(0, 0, 0, 0, 0, 0, 0);        // boot hold then idle
        cyc(0, 0, 1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0, 0, 0);   // load-use
        cyc(0, 1, 1, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0, 0, 0);   // branch beats hazard/if stall
        cyc(0, 1, 0, 0, 0, 0, 0);                             // if stall alone
        cyc(0, 0, 0, 0, 1, 1, 1); cyc(0, 0, 0, 0, 0, 0, 0);   // except wins over ret
        cyc(0, 0, 0, 0, 0, 1, 0);                             // unqualified trap ignored
        repeat (4) cyc(1, 0, 0, 0, 1, 0, 1);                  // ret with dmem busy -> DRAIN
        cyc(0, 0, 0, 0, 1, 0, 1); cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 1, 0);                             // except, dmem stuck
        repeat (7) cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);                  // timeout stays sticky
        cyc(1, 0, 0, 0, 1, 0, 1); cyc(1, 0, 0, 0, 0, 0, 0);   // reset mid-DRAIN
        rst_cyc();
        repeat (4) cyc(0, 0, 0, 0, 0, 0, 0);
        mem_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst_cyc();
                continue;
            end
            mem_r = mem_r ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
            cyc(mem_r, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end
        repeat (3) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
